// File: rtl/sig_timestamp_mc.sv
// ============================================================================
// sig_timestamp_mc : multi-channel edge timestamper, per-channel FIFOs and a
//                    round-robin valid/ready output stream.
// Optional input synchroniser: define SIG_TS_SYNC_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sig_timestamp_mc #(
   parameter int NUM_CH     = 4,
   parameter int TS_W       = 32,
   parameter int FIFO_DEPTH = 4,
   localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_CH-1:0]   sig_in,
   input  logic [2*NUM_CH-1:0] edge_mode,
   input  logic                sync_start,
   input  logic                ovf_clear,
   output logic                ts_valid,
   input  logic                ts_ready,
   output logic [TS_W-1:0]     ts_data,
   output logic [CH_W-1:0]     ts_chan,
   output logic                ts_rise,
   output logic [NUM_CH-1:0]   ts_ovf,
   output logic [TS_W-1:0]     scan_timer
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = TS_W + 1;

   logic [TS_W-1:0]   timer;
   logic [NUM_CH-1:0] sig_s;
   logic [NUM_CH-1:0] sig_prev;
   logic [NUM_CH-1:0] rise;
   logic [NUM_CH-1:0] fall;
   logic [NUM_CH-1:0] push;
   logic [NUM_CH-1:0] wr_en;
   logic [NUM_CH-1:0] ovf_set;
   logic [NUM_CH-1:0] full;
   logic [NUM_CH-1:0] empty;
   logic [NUM_CH-1:0] pop;
   logic [EW-1:0]     head [NUM_CH];
   logic [EW-1:0]     head_sel;
   logic [CH_W-1:0]   arb_ptr;
   logic [CH_W-1:0]   grant;
   logic              grant_any;
   logic              load;

   always_ff @(posedge clk) begin
      if (reset || sync_start) begin
         timer <= '0;
      end else begin
         timer <= timer + TS_W'(1);
      end
   end

   assign scan_timer = timer;

`ifdef SIG_TS_SYNC_EN
   logic [NUM_CH-1:0] sync_q1;
   logic [NUM_CH-1:0] sync_q2;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= sig_in;
         sync_q2 <= sync_q1;
      end
   end

   assign sig_s = sync_q2;
`else
   assign sig_s = sig_in;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         sig_prev <= '0;
      end else begin
         sig_prev <= sig_s;
      end
   end

   assign rise = sig_s & ~sig_prev;
   assign fall = ~sig_s & sig_prev;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [AW:0]   wr_ptr;
      logic [AW:0]   rd_ptr;
      logic [AW:0]   fill;
      logic [EW-1:0] mem [FIFO_DEPTH];

      assign push[i]    = (edge_mode[2*i] & rise[i]) | (edge_mode[2*i+1] & fall[i]);
      assign fill       = wr_ptr - rd_ptr;
      assign empty[i]   = (fill == '0);
      assign full[i]    = (fill == (AW+1)'(FIFO_DEPTH));
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      assign wr_en[i]   = push[i] & (~full[i] | pop[i]);
      assign ovf_set[i] = push[i] & full[i] & ~pop[i];
      assign pop[i]     = load & (grant == CH_W'(i));
      assign head[i]    = mem[rd_ptr[AW-1:0]];

      always_ff @(posedge clk) begin
         if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (wr_en[i]) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop[i])   rd_ptr <= rd_ptr + (AW+1)'(1);
         end
      end

      always_ff @(posedge clk) begin
         if (wr_en[i]) mem[wr_ptr[AW-1:0]] <= {timer, rise[i]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ts_ovf <= '0;
      end else begin
         ts_ovf <= (ovf_clear ? '0 : ts_ovf) | ovf_set;
      end
   end

   // arb_ptr holds the first channel to search, i.e. one past the last grant.
   always_comb begin
      int              j;
      logic [CH_W-1:0] idx;
      grant_any = 1'b0;
      grant     = '0;
      j         = 0;
      idx       = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         j = int'(arb_ptr) + k;
         if (j >= NUM_CH) j = j - NUM_CH;
         idx = CH_W'(j);
         if (!grant_any && !empty[idx]) begin
            grant_any = 1'b1;
            grant     = idx;
         end
      end
   end

   assign load     = grant_any & (~ts_valid | ts_ready);
   assign head_sel = head[grant];

   always_ff @(posedge clk) begin
      if (reset) begin
         ts_valid <= 1'b0;
         ts_data  <= '0;
         ts_chan  <= '0;
         ts_rise  <= 1'b0;
         arb_ptr  <= '0;
      end else if (load) begin
         ts_valid <= 1'b1;
         ts_data  <= head_sel[EW-1:1];
         ts_rise  <= head_sel[0];
         ts_chan  <= grant;
         arb_ptr  <= (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + CH_W'(1);
      end else if (ts_ready) begin
         ts_valid <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_sig_timestamp_mc.sv
// ============================================================================
// tb_sig_timestamp_mc : directed vectors and corner sequences for sig_timestamp_mc.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sig_timestamp_mc;

`ifdef SIG_TS_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  sig_in = '0;
   logic [7:0]  edge_mode = '0;
   logic        sync_start = 1'b0;
   logic        ovf_clear = 1'b0;
   logic        ts_ready = 1'b1;
   logic        ts_valid;
   logic [31:0] ts_data;
   logic [1:0]  ts_chan;
   logic        ts_rise;
   logic [3:0]  ts_ovf;
   logic [31:0] scan_timer;

   logic        sig8 = 1'b0;
   logic [1:0]  mode8 = 2'b01;
   logic        valid8;
   logic [7:0]  data8;
   logic [0:0]  chan8;
   logic        rise8;
   logic [0:0]  ovf8;
   logic [7:0]  scan8;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int         ch;
      logic [1:0] mode;
      logic       pre;
      int         t;
      logic       exp_ev;
      logic       exp_rise;
   } vec_t;

   vec_t        vecs[6];
   logic [34:0] q[$];
   logic [31:0] tk[6];

   sig_timestamp_mc #(.NUM_CH(4), .TS_W(32), .FIFO_DEPTH(4)) u_dut (
      .clk(clk), .reset(reset), .sig_in(sig_in), .edge_mode(edge_mode),
      .sync_start(sync_start), .ovf_clear(ovf_clear), .ts_valid(ts_valid),
      .ts_ready(ts_ready), .ts_data(ts_data), .ts_chan(ts_chan), .ts_rise(ts_rise),
      .ts_ovf(ts_ovf), .scan_timer(scan_timer)
   );

   sig_timestamp_mc #(.NUM_CH(1), .TS_W(8), .FIFO_DEPTH(2)) u_dut8 (
      .clk(clk), .reset(reset), .sig_in(sig8), .edge_mode(mode8),
      .sync_start(1'b0), .ovf_clear(1'b0), .ts_valid(valid8),
      .ts_ready(1'b1), .ts_data(data8), .ts_chan(chan8), .ts_rise(rise8),
      .ts_ovf(ovf8), .scan_timer(scan8)
   );

   always #5 clk = ~clk;

   // Inputs change at posedge+1, so valid/ready seen here hold through the next posedge.
   always @(negedge clk) begin
      if (!reset && ts_valid && ts_ready) q.push_back({ts_chan, ts_rise, ts_data});
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic pulse_sync();
      sync_start = 1'b1;
      step();
      sync_start = 1'b0;
   endtask

   task automatic wait_timer(input logic [31:0] v);
      int n = 0;
      while (scan_timer !== v && n < 400) begin
         step();
         n++;
      end
      chk("wait_timer", scan_timer, v);
   endtask

   task automatic wait_q(input int nmin, input int budget);
      int n = 0;
      while (q.size() < nmin && n < budget) begin
         step();
         n++;
      end
      chk("event_arrival", (q.size() >= nmin), 1'b1);
   endtask

   task automatic check_ev(input string nm, input int idx, input logic [31:0] d,
                           input logic [1:0] c, input logic r);
      logic [34:0] e;
      if (idx < q.size()) e = q[idx];
      else                e = '1;
      chk({nm, "_data"}, e[31:0], d);
      chk({nm, "_chan"}, e[34:33], c);
      chk({nm, "_rise"}, e[32], r);
   endtask

   initial begin
      int n;
      vecs[0] = '{ch: 0, mode: 2'b01, pre: 1'b0, t: 10, exp_ev: 1'b1, exp_rise: 1'b1};
      vecs[1] = '{ch: 1, mode: 2'b10, pre: 1'b1, t: 15, exp_ev: 1'b1, exp_rise: 1'b0};
      vecs[2] = '{ch: 2, mode: 2'b00, pre: 1'b0, t: 12, exp_ev: 1'b0, exp_rise: 1'b0};
      vecs[3] = '{ch: 3, mode: 2'b11, pre: 1'b1, t: 7,  exp_ev: 1'b1, exp_rise: 1'b0};
      vecs[4] = '{ch: 2, mode: 2'b01, pre: 1'b1, t: 9,  exp_ev: 1'b0, exp_rise: 1'b0};
      vecs[5] = '{ch: 3, mode: 2'b10, pre: 1'b0, t: 5,  exp_ev: 1'b0, exp_rise: 1'b0};

      repeat (3) step();
      chk("rst_valid", ts_valid, 1'b0);
      chk("rst_data", ts_data, 32'd0);
      chk("rst_chan", ts_chan, 2'd0);
      chk("rst_ovf", ts_ovf, 4'd0);
      chk("rst_timer", scan_timer, 32'd0);
      reset = 1'b0;
      step();
      chk("timer_first_inc", scan_timer, 32'd1);

      for (int v = 0; v < 6; v++) begin
         edge_mode = '0;
         sig_in    = '0;
         sig_in[vecs[v].ch] = vecs[v].pre;
         repeat (5) step();
         q.delete();
         edge_mode[2*vecs[v].ch +: 2] = vecs[v].mode;
         pulse_sync();
         wait_timer(vecs[v].t);
         sig_in[vecs[v].ch] = ~vecs[v].pre;
         if (vecs[v].exp_ev) begin
            wait_q(1, 10);
            check_ev("vec", 0, 32'(vecs[v].t + LAT), 2'(vecs[v].ch), vecs[v].exp_rise);
            repeat (4) step();
            chk("vec_single_beat", q.size(), 1);
         end else begin
            repeat (8) step();
            chk("vec_no_event", q.size(), 0);
         end
      end

      // Both edges on one channel, captured in order.
      edge_mode = '0; sig_in = '0;
      repeat (5) step();
      q.delete();
      edge_mode[3:2] = 2'b11;
      pulse_sync();
      wait_timer(20);
      sig_in[1] = 1'b1;
      wait_timer(25);
      sig_in[1] = 1'b0;
      wait_q(2, 10);
      check_ev("both_first", 0, 32'(20 + LAT), 2'd1, 1'b1);
      check_ev("both_second", 1, 32'(25 + LAT), 2'd1, 1'b0);

      // Edge coincident with sync_start captures the pre-clear value.
      edge_mode = '0; sig_in = '0;
      repeat (5) step();
      q.delete();
      edge_mode[5:4] = 2'b01;
      pulse_sync();
      wait_timer(100);
      sync_start = 1'b1;
      sig_in[2]  = 1'b1;
      step();
      sync_start = 1'b0;
      chk("sync_clear", scan_timer, 32'd0);
      step();
      chk("sync_count", scan_timer, 32'd1);
      wait_q(1, 10);
      check_ev("sync_edge", 0, (LAT == 0) ? 32'd100 : 32'(LAT - 1), 2'd2, 1'b1);

      // Overflow with consumer stalled, then drain in order.
      edge_mode = '0; sig_in = '0;
      repeat (5) step();
      q.delete();
      ts_ready = 1'b0;
      edge_mode[7:6] = 2'b01;
      for (int k = 0; k < 6; k++) begin
         sig_in[3] = 1'b1;
         tk[k] = scan_timer;
         step(); step();
         sig_in[3] = 1'b0;
         step(); step();
      end
      repeat (LAT + 3) step();
      chk("ovf_set", ts_ovf, 4'b1000);
      chk("ovf_valid_held", ts_valid, 1'b1);
      chk("ovf_head_data", ts_data, tk[0] + 32'(LAT));
      ovf_clear = 1'b1;
      step();
      ovf_clear = 1'b0;
      chk("ovf_clear", ts_ovf, 4'b0000);
      ts_ready = 1'b1;
      wait_q(5, 20);
      repeat (4) step();
      chk("drain_count", q.size(), 5);
      for (int k = 0; k < 5; k++) check_ev("drain", k, tk[k] + 32'(LAT), 2'd3, 1'b1);

      // Four channels at once: round-robin order and stall stability.
      edge_mode = '0; sig_in = '0;
      repeat (5) step();
      q.delete();
      edge_mode = 8'h55;
      pulse_sync();
      wait_timer(50);
      sig_in = 4'hF;
      n = 0;
      while (!ts_valid && n < 10) begin
         step();
         n++;
      end
      chk("burst_valid", ts_valid, 1'b1);
      chk("burst_first_chan", ts_chan, 2'd0);
      step();
      chk("burst_second_chan", ts_chan, 2'd1);
      ts_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("hold_valid", ts_valid, 1'b1);
         chk("hold_chan", ts_chan, 2'd1);
         chk("hold_data", ts_data, 32'(50 + LAT));
      end
      ts_ready = 1'b1;
      wait_q(4, 10);
      for (int k = 0; k < 4; k++) check_ev("burst", k, 32'(50 + LAT), 2'(k), 1'b1);

      // 8-bit timer wrap.
      n = 0;
      while (scan8 !== 8'd255 && n < 300) begin
         step();
         n++;
      end
      chk("wrap_reach", scan8, 8'd255);
      step();
      chk("wrap_zero", scan8, 8'd0);
      step();
      sig8 = 1'b1;
      n = 0;
      while (!valid8 && n < 10) begin
         step();
         n++;
      end
      chk("wrap_valid", valid8, 1'b1);
      chk("wrap_data", data8, 8'(1 + LAT));
      chk("wrap_rise", rise8, 1'b1);
      chk("wrap_ovf", ovf8, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
